// File: rtl/hps_regbank_cam_cfg.sv
// HPS lightweight-bridge register bank: generic control registers, CTRL/STATUS/CLEAR,
// and a camera sensor-command queue with a show-ahead output stage for the SCCB master.
module hps_regbank_cam_cfg #(
  parameter int N_REGS     = 16,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int NUM_CAM    = 2,
  parameter logic [N_REGS*32-1:0] RESET_VALS = '0,
  localparam int CAM_W     = (NUM_CAM > 1) ? $clog2(NUM_CAM) : 1
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  input  logic                  avs_chipselect,
  input  logic                  avs_write,
  input  logic                  avs_read,
  input  logic [15:0]           avs_address,
  input  logic [DATA_W-1:0]     avs_writedata,
  input  logic [3:0]            avs_byteenable,
  output logic [DATA_W-1:0]     avs_readdata,
  output logic                  avs_readdatavalid,
  output logic [N_REGS*32-1:0]  regs_q,
  output logic                  fb_start,
  output logic                  cfg_valid,
  input  logic                  cfg_ready,
  output logic [CAM_W-1:0]      cfg_cam,
  output logic [15:0]           cfg_addr,
  output logic [7:0]            cfg_data
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LW    = AW + 1;
  localparam int ENT_W = CAM_W + 24;
  localparam int GW    = (N_REGS > 1) ? $clog2(N_REGS) : 1;
  localparam logic [15:0] ADDR_CTRL   = 16'hFFFF;
  localparam logic [15:0] ADDR_STATUS = 16'hFFFE;
  localparam logic [15:0] ADDR_CLEAR  = 16'hFFFD;

  typedef enum logic [0:0] {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [31:0]        r_regs [N_REGS];
  logic [ENT_W-1:0]   r_mem [FIFO_DEPTH];
  logic [AW:0]        r_wptr;
  logic [AW:0]        r_rptr;
  logic [LW-1:0]      r_fcnt;
  logic               r_enable;
  logic               r_fb_start;
  logic               r_overflow;
  logic [15:0]        r_done_cnt;
  logic [31:0]        r_readdata;
  logic               r_rdv;
  logic [CAM_W-1:0]   r_cfg_cam;
  logic [15:0]        r_cfg_addr;
  logic [7:0]         r_cfg_data;

  logic               w_wr, w_rd;
  logic               w_is_gen, w_is_ctrl, w_is_status, w_is_clear, w_is_cmd;
  logic [GW-1:0]      w_gidx;
  logic               w_fifo_ne, w_hs, w_pop, w_push_req, w_push, w_drop;
  logic [LW-1:0]      w_level;
  logic [CAM_W-1:0]   w_cam;
  logic [ENT_W-1:0]   w_entry;
  logic [ENT_W-1:0]   w_head;
  logic [31:0]        w_rdata;

  assign w_wr        = avs_chipselect & avs_write;
  assign w_rd        = avs_chipselect & avs_read;
  assign w_is_gen    = (avs_address < 16'(N_REGS));
  assign w_is_ctrl   = (avs_address == ADDR_CTRL);
  assign w_is_status = (avs_address == ADDR_STATUS);
  assign w_is_clear  = (avs_address == ADDR_CLEAR);
  assign w_is_cmd    = ~w_is_gen & ~w_is_ctrl & ~w_is_status & ~w_is_clear;
  assign w_gidx      = avs_address[GW-1:0];

  // Level spans FIFO plus output register, so the output slot counts toward capacity.
  assign cfg_valid   = (r_state == ST_FULL);
  assign w_fifo_ne   = (r_fcnt != {LW{1'b0}});
  assign w_level     = r_fcnt + LW'(cfg_valid);
  assign w_hs        = cfg_valid & cfg_ready;
  assign w_pop       = w_fifo_ne & (~cfg_valid | cfg_ready);
  assign w_push_req  = w_wr & w_is_cmd;
  assign w_push      = w_push_req & ((w_level < LW'(FIFO_DEPTH)) | w_hs);
  assign w_drop      = w_push_req & ~w_push;
  assign w_entry     = {w_cam, avs_address, avs_writedata[7:0]};
  assign w_head      = r_mem[r_rptr[AW-1:0]];

  // Out-of-range camera indices are clamped to the last camera.
  always_comb begin
    if ({1'b0, avs_writedata[8 +: CAM_W]} >= (CAM_W+1)'(NUM_CAM)) begin
      w_cam = CAM_W'(NUM_CAM - 1);
    end else begin
      w_cam = avs_writedata[8 +: CAM_W];
    end
  end

  // Command storage array; pointers carry the flush on reset.
  always_ff @(posedge clk_sys) begin
    if (w_push) begin
      r_mem[r_wptr[AW-1:0]] <= w_entry;
    end
  end

  // Queue pointers and occupancy.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_fcnt <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_pop)  r_rptr <= r_rptr + (AW+1)'(1);
      r_fcnt <= r_fcnt + LW'(w_push) - LW'(w_pop);
    end
  end

  // Output stage state register.
  always_ff @(posedge clk_sys) begin
    if (reset) r_state <= ST_EMPTY;
    else       r_state <= w_state_nxt;
  end

  // Output stage next state: load when empty, reload back-to-back on handshake.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: begin
        if (w_fifo_ne) w_state_nxt = ST_FULL;
        else           w_state_nxt = ST_EMPTY;
      end
      ST_FULL: begin
        if (cfg_ready & ~w_fifo_ne) w_state_nxt = ST_EMPTY;
        else                        w_state_nxt = ST_FULL;
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  // Output command register, held stable until the head is popped.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_cfg_cam  <= '0;
      r_cfg_addr <= 16'h0000;
      r_cfg_data <= 8'h00;
    end else if (w_pop) begin
      {r_cfg_cam, r_cfg_addr, r_cfg_data} <= w_head;
    end
  end

  // Generic registers with byte-enable writes.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      for (int i = 0; i < N_REGS; i++) r_regs[i] <= RESET_VALS[32*i +: 32];
    end else if (w_wr && w_is_gen) begin
      for (int b = 0; b < 4; b++) begin
        if (avs_byteenable[b]) r_regs[w_gidx][8*b +: 8] <= avs_writedata[8*b +: 8];
      end
    end
  end

  // CTRL, fb_start edge pulse, sticky overflow and handshake counter.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_enable   <= 1'b0;
      r_fb_start <= 1'b0;
      r_overflow <= 1'b0;
      r_done_cnt <= 16'h0000;
    end else begin
      r_fb_start <= w_wr & w_is_ctrl & avs_writedata[0] & ~r_enable;
      if (w_wr && w_is_ctrl) r_enable <= avs_writedata[0];
      if (w_drop) r_overflow <= 1'b1;
      else if (w_wr && w_is_clear && avs_writedata[0]) r_overflow <= 1'b0;
      if (w_wr && w_is_clear && avs_writedata[1]) r_done_cnt <= {15'd0, w_hs};
      else if (w_hs) r_done_cnt <= r_done_cnt + 16'd1;
    end
  end

  // Readback mux over pre-write state.
  always_comb begin
    w_rdata = 32'h0000_0000;
    if (w_is_gen) begin
      w_rdata = r_regs[w_gidx];
    end else if (w_is_ctrl) begin
      w_rdata = {31'd0, r_enable};
    end else if (w_is_status) begin
      w_rdata = {r_done_cnt, 6'd0, cfg_valid, r_overflow, 8'(w_level)};
    end else begin
      w_rdata = 32'h0000_0000;
    end
  end

  // Registered read response.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_readdata <= 32'h0000_0000;
      r_rdv      <= 1'b0;
    end else begin
      r_rdv <= w_rd;
      if (w_rd) r_readdata <= w_rdata;
    end
  end

  for (genvar g = 0; g < N_REGS; g++) begin : g_regs_q
    assign regs_q[32*g +: 32] = r_regs[g];
  end

  assign avs_readdata      = r_readdata;
  assign avs_readdatavalid = r_rdv;
  assign fb_start          = r_fb_start;
  assign cfg_cam           = r_cfg_cam;
  assign cfg_addr          = r_cfg_addr;
  assign cfg_data          = r_cfg_data;

endmodule

// File: tb/tb_hps_regbank_cam_cfg.sv
// Bench for hps_regbank_cam_cfg: directed scenarios plus random traffic, all checked
// each cycle against a transaction-level model (register array + command queue).
module tb_hps_regbank_cam_cfg;
  localparam int N_REGS = 16, FIFO_DEPTH = 16, NUM_CAM = 2, CAM_W = 1;

  function automatic logic [N_REGS*32-1:0] mk_rv();
    logic [N_REGS*32-1:0] v;
    v = '0;
    for (int i = 0; i < N_REGS; i++)
      if (i != 3) v[32*i +: 32] = 32'h5A00_0000 + 32'(i) * 32'h0101_0011;
    return v;
  endfunction
  localparam logic [N_REGS*32-1:0] RV = mk_rv();

  logic clk_sys = 1'b0;
  logic reset = 1'b1, avs_chipselect = 1'b0, avs_write = 1'b0, avs_read = 1'b0;
  logic [15:0] avs_address = 16'h0000;
  logic [31:0] avs_writedata = 32'h0;
  logic [3:0]  avs_byteenable = 4'h0;
  logic cfg_ready = 1'b0;
  logic [31:0] avs_readdata;
  logic avs_readdatavalid, fb_start, cfg_valid;
  logic [N_REGS*32-1:0] regs_q;
  logic [CAM_W-1:0] cfg_cam;
  logic [15:0] cfg_addr;
  logic [7:0]  cfg_data;

  hps_regbank_cam_cfg #(.N_REGS(N_REGS), .DATA_W(32), .FIFO_DEPTH(FIFO_DEPTH),
                        .NUM_CAM(NUM_CAM), .RESET_VALS(RV)) dut (
    .clk_sys(clk_sys), .reset(reset), .avs_chipselect(avs_chipselect),
    .avs_write(avs_write), .avs_read(avs_read), .avs_address(avs_address),
    .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
    .avs_readdata(avs_readdata), .avs_readdatavalid(avs_readdatavalid),
    .regs_q(regs_q), .fb_start(fb_start), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready), .cfg_cam(cfg_cam), .cfg_addr(cfg_addr), .cfg_data(cfg_data));

  always #5 clk_sys = ~clk_sys;

  typedef struct {logic [CAM_W-1:0] cam; logic [15:0] addr; logic [7:0] data; int stamp;} cmd_t;
  cmd_t        m_q[$];
  logic [31:0] m_regs[N_REGS];
  logic        m_en = 1'b0, m_ovf = 1'b0, m_valid = 1'b0, m_rdv = 1'b0, m_fb = 1'b0;
  logic [15:0] m_done = 16'h0;
  logic [31:0] m_rdata = 32'h0;
  int          edge_n = 0;
  int          errors = 0, checks = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [15:0] a);
    if (a < 16'(N_REGS)) return m_regs[int'(a)];
    else if (a == 16'hFFFF) return {31'd0, m_en};
    else if (a == 16'hFFFE) return {m_done, 6'd0, m_valid, m_ovf, 8'(m_q.size())};
    else return 32'h0;
  endfunction

  // One clock: advance the model with the inputs sampled at this edge, then compare.
  task automatic step();
    logic hs, wrs, rds, is_cmd;
    int lvl;
    cmd_t c;
    @(posedge clk_sys);
    edge_n++;
    wrs = avs_chipselect & avs_write;
    rds = avs_chipselect & avs_read;
    if (reset) begin
      for (int i = 0; i < N_REGS; i++) m_regs[i] = RV[32*i +: 32];
      m_en = 0; m_ovf = 0; m_done = 0; m_q.delete();
      m_valid = 0; m_rdv = 0; m_rdata = 0; m_fb = 0;
    end else begin
      hs = m_valid & cfg_ready;
      if (rds) m_rdata = m_read(avs_address);
      m_rdv = rds;
      m_fb = 0;
      is_cmd = wrs && (avs_address >= 16'(N_REGS)) && (avs_address < 16'hFFFD);
      if (wrs && avs_address < 16'(N_REGS)) begin
        for (int b = 0; b < 4; b++)
          if (avs_byteenable[b]) m_regs[int'(avs_address)][8*b +: 8] = avs_writedata[8*b +: 8];
      end else if (wrs && avs_address == 16'hFFFF) begin
        m_fb = avs_writedata[0] & ~m_en;
        m_en = avs_writedata[0];
      end else if (wrs && avs_address == 16'hFFFD) begin
        if (avs_writedata[0]) m_ovf = 0;
        if (avs_writedata[1]) m_done = 0;
      end
      lvl = m_q.size();
      if (hs) begin
        void'(m_q.pop_front());
        m_done = m_done + 16'd1;
      end
      if (is_cmd) begin
        if (lvl < FIFO_DEPTH || hs) begin
          c.cam  = (int'(avs_writedata[8 +: CAM_W]) >= NUM_CAM) ? CAM_W'(NUM_CAM-1) : avs_writedata[8 +: CAM_W];
          c.addr = avs_address; c.data = avs_writedata[7:0]; c.stamp = edge_n;
          m_q.push_back(c);
        end else m_ovf = 1;
      end
      // A queued command reaches the output one edge after it entered the queue.
      m_valid = 0;
      if (m_q.size() > 0) m_valid = (m_q[0].stamp <= edge_n - 1);
    end
    #1;
    for (int i = 0; i < N_REGS; i++) check_eq("regs_q", regs_q[32*i +: 32], m_regs[i]);
    check_eq("rdv", avs_readdatavalid, m_rdv);
    check_eq("rdata", avs_readdata, m_rdata);
    check_eq("fb_start", fb_start, m_fb);
    check_eq("cfg_valid", cfg_valid, m_valid);
    if (m_valid) begin
      check_eq("cfg_cam", cfg_cam, m_q[0].cam);
      check_eq("cfg_addr", cfg_addr, m_q[0].addr);
      check_eq("cfg_data", cfg_data, m_q[0].data);
    end
  endtask

  task automatic idle(input int n);
    avs_chipselect = 0; avs_write = 0; avs_read = 0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wr_acc(input logic [15:0] a, input logic [31:0] d, input logic [3:0] be);
    avs_chipselect = 1; avs_write = 1; avs_read = 0;
    avs_address = a; avs_writedata = d; avs_byteenable = be;
    step();
    avs_chipselect = 0; avs_write = 0;
  endtask

  task automatic rd_acc(input logic [15:0] a);
    avs_chipselect = 1; avs_write = 0; avs_read = 1; avs_address = a;
    step();
    avs_chipselect = 0; avs_read = 0;
  endtask

  initial begin
    int pulses;
    // Reset and readback of reset values
    reset = 1; idle(2); reset = 0;
    check_eq("rst_cfg_valid", cfg_valid, 1'b0);
    check_eq("rst_cfg_addr", cfg_addr, 16'h0);
    for (int i = 0; i < N_REGS; i++) begin
      rd_acc(16'(i));
      check_eq("rst_readback", avs_readdata, RV[32*i +: 32]);
      check_eq("rst_rdv", avs_readdatavalid, 1'b1);
    end
    rd_acc(16'hFFFE);
    check_eq("status_rst", avs_readdata, 32'h0);
    idle(1);
    check_eq("rdv_drop", avs_readdatavalid, 1'b0);

    // Byte-enable write
    wr_acc(16'd3, 32'hAABBCCDD, 4'b0101);
    check_eq("be_write", regs_q[3*32 +: 32], 32'h00BB00DD);
    rd_acc(16'd3);
    check_eq("be_readback", avs_readdata, 32'h00BB00DD);

    // First-command latency and hold
    cfg_ready = 0;
    wr_acc(16'h3008, 32'h0000_0182, 4'hF);
    check_eq("lat_t1", cfg_valid, 1'b0);
    idle(1);
    check_eq("lat_t2", cfg_valid, 1'b1);
    check_eq("cmd_cam", cfg_cam, 1'b1);
    check_eq("cmd_addr", cfg_addr, 16'h3008);
    check_eq("cmd_data", cfg_data, 8'h82);
    idle(10);
    check_eq("cmd_hold", cfg_addr, 16'h3008);
    cfg_ready = 1; idle(1); cfg_ready = 0;
    rd_acc(16'hFFFE);
    check_eq("done_cnt", avs_readdata[31:16], 16'd1);

    // Overflow on the 17th push, clear, then back-to-back drain
    for (int k = 0; k < 17; k++) wr_acc(16'h2000 + 16'(k), 32'(k), 4'hF);
    rd_acc(16'hFFFE);
    check_eq("ovf_status", avs_readdata[9:0], 10'h310);
    wr_acc(16'hFFFD, 32'h1, 4'hF);
    rd_acc(16'hFFFE);
    check_eq("ovf_clear", avs_readdata[8], 1'b0);
    cfg_ready = 1;
    for (int k = 0; k < 16; k++) begin
      check_eq("drain_valid", cfg_valid, 1'b1);
      check_eq("drain_addr", cfg_addr, 16'h2000 + 16'(k));
      step();
    end
    cfg_ready = 0;
    check_eq("drain_empty", cfg_valid, 1'b0);

    // fb_start pulses on CTRL writes 1,1,0,1
    pulses = 0;
    foreach (m_regs[j]) if (j < 4) begin
      wr_acc(16'hFFFF, (j == 2) ? 32'h0 : 32'h1, 4'hF);
      pulses += int'(fb_start);
      idle(1);
      pulses += int'(fb_start);
    end
    check_eq("fb_pulses", pulses, 2);

    // Reset in the middle of a pending handshake
    for (int k = 0; k < 6; k++) wr_acc(16'h4000 + 16'(k), 32'h100 + 32'(k), 4'hF);
    idle(2);
    check_eq("pre_rst_valid", cfg_valid, 1'b1);
    cfg_ready = 1; reset = 1; idle(1); reset = 0; cfg_ready = 0;
    check_eq("mid_rst_valid", cfg_valid, 1'b0);
    check_eq("mid_rst_addr", cfg_addr, 16'h0);
    idle(3);
    rd_acc(16'hFFFE);
    check_eq("mid_rst_status", avs_readdata, 32'h0);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 299) == 0);
      avs_chipselect = ($urandom_range(0, 7) != 0);
      avs_write = 1'($urandom_range(0, 1));
      avs_read = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 5))
        0: avs_address = 16'($urandom_range(0, N_REGS - 1));
        1: avs_address = 16'hFFFF;
        2: avs_address = 16'hFFFE;
        3: avs_address = ($urandom_range(0, 3) == 0) ? 16'hFFFD : 16'h0100;
        default: avs_address = 16'($urandom_range(N_REGS, 32'hFFFC));
      endcase
      avs_writedata = $urandom;
      avs_byteenable = 4'($urandom);
      cfg_ready = (c < 1500) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 0);
      step();
    end
    reset = 0;
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
